// File: rtl/message_stream_packetizer.sv
// -----------------------------------------------------------------------------
// message_stream_packetizer
//
// Wraps a raw sample stream into message stream packets: one header word
// followed by N payload words. Samples are buffered in an internal FIFO.
// A full packet (PACKET_LENGTH words) is emitted as soon as enough samples
// are held. A flush request emits a shorter packet holding whatever is
// buffered. The output is a free-running valid stream with no backpressure.
//
// Header word : {1'b1, N[LOG_MAX_PACKET_LENGTH-1:0], seq}
// Payload word: {1'b0, sample}
//
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   in_data  - sample payload (WIDTH-1 bits)
//   in_nd    - in_data valid this cycle
//   flush    - single-cycle pulse, emit a short packet of buffered samples
//   out_data - message stream word (registered)
//   out_nd   - out_data valid (registered)
//   error    - sticky FIFO overflow flag (registered, cleared only by reset)
// -----------------------------------------------------------------------------
module message_stream_packetizer #(
    parameter int WIDTH                 = 32,
    parameter int PACKET_LENGTH         = 16,
    parameter int LOG_MAX_PACKET_LENGTH = 10,
    parameter int BUFFER_LENGTH         = 64,
    parameter int LOG_BUFFER_LENGTH     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-2:0] in_data,
    input  logic             in_nd,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
);

    localparam int SEQ_W  = WIDTH - 1 - LOG_MAX_PACKET_LENGTH;
    localparam int LEN_W  = LOG_MAX_PACKET_LENGTH;
    localparam int PTR_W  = LOG_BUFFER_LENGTH;
    localparam int FILL_W = LOG_BUFFER_LENGTH + 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(BUFFER_LENGTH);
    localparam logic [FILL_W-1:0] FILL_PKT  = FILL_W'(PACKET_LENGTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    logic [WIDTH-2:0]  mem_r [BUFFER_LENGTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [FILL_W-1:0] fill_r;
    logic [SEQ_W-1:0]  seq_r;
    logic [LEN_W-1:0]  remaining_r;
    logic              flush_pending_r;
    state_t            state_r;
    logic [WIDTH-1:0]  out_data_r;
    logic              out_nd_r;
    logic              error_r;

    state_t            state_s;
    logic [LEN_W-1:0]  remaining_s;
    logic [SEQ_W-1:0]  seq_s;
    logic [WIDTH-1:0]  out_data_s;
    logic              out_nd_s;
    logic              rd_s;
    logic              clear_flush_s;
    logic              wr_s;
    logic              overflow_s;
    logic [FILL_W-1:0] fill_s;

    // Pointer advance with explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUFFER_LENGTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Packet sequencing: decides header start, payload pops and next outputs.
    always_comb begin
        state_s       = state_r;
        remaining_s   = remaining_r;
        seq_s         = seq_r;
        out_data_s    = out_data_r;
        out_nd_s      = 1'b0;
        rd_s          = 1'b0;
        clear_flush_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fill_r >= FILL_PKT) begin
                    out_data_s  = {1'b1, LEN_W'(PACKET_LENGTH), seq_r};
                    out_nd_s    = 1'b1;
                    remaining_s = LEN_W'(PACKET_LENGTH);
                    state_s     = PAYLOAD;
                end else if (flush_pending_r && (fill_r != {FILL_W{1'b0}})) begin
                    out_data_s    = {1'b1, LEN_W'(fill_r), seq_r};
                    out_nd_s      = 1'b1;
                    remaining_s   = LEN_W'(fill_r);
                    state_s       = PAYLOAD;
                    clear_flush_s = 1'b1;
                end else if (flush_pending_r) begin
                    // Nothing buffered: drop the request, never send a bare header.
                    clear_flush_s = 1'b1;
                end else begin
                    out_nd_s = 1'b0;
                end
            end
            PAYLOAD: begin
                rd_s        = 1'b1;
                out_data_s  = {1'b0, mem_r[rd_ptr_r]};
                out_nd_s    = 1'b1;
                remaining_s = remaining_r - LEN_W'(1);
                if (remaining_r == LEN_W'(1)) begin
                    seq_s   = seq_r + SEQ_W'(1);
                    state_s = IDLE;
                end else begin
                    state_s = PAYLOAD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FIFO accounting: a read in the same cycle frees room for a write at full.
    always_comb begin
        wr_s       = in_nd && ((fill_r != FILL_FULL) || rd_s);
        overflow_s = in_nd && (fill_r == FILL_FULL) && !rd_s;
        case ({wr_s, rd_s})
            2'b10:   fill_s = fill_r + FILL_W'(1);
            2'b01:   fill_s = fill_r - FILL_W'(1);
            default: fill_s = fill_r;
        endcase
    end

    // Sample storage; contents need no reset since fill gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Control state, FIFO pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            fill_r          <= {FILL_W{1'b0}};
            seq_r           <= {SEQ_W{1'b0}};
            remaining_r     <= {LEN_W{1'b0}};
            flush_pending_r <= 1'b0;
            state_r         <= IDLE;
            out_data_r      <= {WIDTH{1'b0}};
            out_nd_r        <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            fill_r      <= fill_s;
            seq_r       <= seq_s;
            remaining_r <= remaining_s;
            state_r     <= state_s;
            out_data_r  <= out_data_s;
            out_nd_r    <= out_nd_s;
            // A new flush on the clearing edge wins, so the request is not lost.
            flush_pending_r <= flush || (flush_pending_r && !clear_flush_s);
            if (overflow_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign out_data = out_data_r;
    assign out_nd   = out_nd_r;
    assign error    = error_r;

endmodule

// File: tb/tb_message_stream_packetizer.sv
module tb_message_stream_packetizer;

    logic        clk;
    logic        rst_n;
    logic [30:0] in_data;
    logic        in_nd;
    logic        flush;
    logic [31:0] out_data;
    logic        out_nd;
    logic        error;

    int unsigned n_cmp;
    int unsigned n_fail;
    int unsigned run_len;
    int unsigned max_run;
    logic [31:0] exp_q[$];

    message_stream_packetizer #(
        .WIDTH                (32),
        .PACKET_LENGTH        (4),
        .LOG_MAX_PACKET_LENGTH(10),
        .BUFFER_LENGTH        (8),
        .LOG_BUFFER_LENGTH    (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_nd   (in_nd),
        .flush   (flush),
        .out_data(out_data),
        .out_nd  (out_nd),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid output word is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (out_nd) begin
            logic [31:0] e;
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_word: got %h, required no output", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL out_word: got %h, required %h", out_data, e);
                end
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_nd = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        max_run = 0;
    endtask

    task automatic write_words(input logic [30:0] first, input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            in_nd   = 1'b1;
            in_data = first + 31'(i);
        end
        @(negedge clk);
        in_nd = 1'b0;
    endtask

    task automatic push_packet(input logic [31:0] hdr, input logic [31:0] first, input int count);
        exp_q.push_back(hdr);
        for (int i = 0; i < count; i++) exp_q.push_back(first + 32'(i));
    endtask

    // Bounded wait for the scoreboard to empty, then a quiet window.
    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        run_len = 0;
        max_run = 0;
        rst_n   = 1'b0;
        in_nd   = 1'b0;
        flush   = 1'b0;
        in_data = 31'd0;
        #1;
        check("reset_out_data", out_data, 32'h0);
        check("reset_out_nd", {31'd0, out_nd}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single full packet with latency check.
        push_packet(32'h8080_0000, 32'h1, 4);
        write_words(31'h1, 4);
        check("latency_e0_nd", {31'd0, out_nd}, 32'd0);
        @(negedge clk);
        check("latency_e1_nd", {31'd0, out_nd}, 32'd1);
        check("latency_e1_hdr", out_data, 32'h8080_0000);
        drain("pkt1_drain", 20);
        check("pkt1_run_len", max_run, 32'd5);

        // Two packets back to back, ninth word stays buffered.
        do_reset();
        push_packet(32'h8080_0000, 32'h1, 4);
        push_packet(32'h8080_0001, 32'h5, 4);
        write_words(31'h1, 9);
        drain("b2b_drain", 40);
        repeat (10) @(negedge clk);
        check("b2b_run_len", max_run, 32'd10);

        // Flush short packet, then flush with empty buffer.
        do_reset();
        push_packet(32'h8060_0000, 32'hA, 3);
        write_words(31'hA, 3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drain("flush_drain", 20);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drain("empty_flush_quiet", 2);
        check("flush_error", {31'd0, error}, 32'd0);

        // All-ones samples never set the header marker bit.
        do_reset();
        exp_q.push_back(32'h8080_0000);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_nd   = 1'b1;
            in_data = 31'h7FFF_FFFF;
        end
        @(negedge clk);
        in_nd = 1'b0;
        drain("allones_drain", 20);

        // Continuous input: word 25 and every fifth word after it are dropped.
        do_reset();
        begin
            logic [31:0] acc[$];
            for (int v = 1; v <= 60; v++) begin
                if (!(v >= 25 && ((v - 25) % 5) == 0)) acc.push_back(32'(v));
            end
            for (int p = 0; p < acc.size() / 4; p++) begin
                exp_q.push_back(32'h8080_0000 | 32'(p));
                for (int j = 0; j < 4; j++) exp_q.push_back(acc[p * 4 + j]);
            end
        end
        for (int v = 1; v <= 60; v++) begin
            @(negedge clk);
            check("overflow_error_flag", {31'd0, error}, (v >= 26) ? 32'd1 : 32'd0);
            in_nd   = 1'b1;
            in_data = 31'(v);
        end
        @(negedge clk);
        in_nd = 1'b0;
        drain("overflow_drain", 60);
        check("overflow_error_sticky", {31'd0, error}, 32'd1);

        // Asynchronous reset mid-payload; sequence number restarts at 0.
        do_reset();
        push_packet(32'h8080_0000, 32'h1, 4);
        write_words(31'h1, 4);
        drain("pre_reset_drain", 20);
        push_packet(32'h8080_0001, 32'h5, 4);
        write_words(31'h5, 4);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_out_nd", {31'd0, out_nd}, 32'd0);
        check("async_rst_out_data", out_data, 32'h0);
        check("async_rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_packet(32'h8080_0000, 32'h11, 4);
        write_words(31'h11, 4);
        drain("post_reset_drain", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
